// File: rtl/seg_scan_pkg.sv
// Shared types and active-low segment constants for the seg_scan display scanner.
package seg_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index n holds the {g,f,e,d,c,b,a} active-low pattern for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_scan_seg7_dec.sv
// Combinational 4-bit hex to active-low 7-segment decoder.
module seg7_dec
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup of the hex pattern.
    always_comb begin
        seg_o = SEG_HEX[nib_i];
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed common-anode 7-segment scanner with per-frame digit snapshot.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_WIDTH  = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int BLANK_CYC   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           sft_rst,
    input  logic                           en,
    input  logic [NUM_DIGITS*DATA_WIDTH-1:0] digits_i,
    output logic [NUM_DIGITS-1:0]          an_o,
    output logic [6:0]                     seg_o,
    output logic                           frame_o
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int TMR_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [TMR_W-1:0] BLANK_LD = TMR_W'(BLANK_CYC - 1);
    localparam logic [TMR_W-1:0] SHOW_LD  = TMR_W'(REFRESH_DIV - 1);

    state_e                                state_q, state_d;
    logic [IDX_W-1:0]                      idx_q, idx_d;
    logic [TMR_W-1:0]                      timer_q, timer_d;
    logic [NUM_DIGITS-1:0][DATA_WIDTH-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]                 an_q, an_d;
    logic [6:0]                            seg_q, seg_d;
    logic                                  frame_q, frame_d;

    logic [3:0] nib_s;
    logic [6:0] dec_s;
    logic       blank_digit_s;

    // Next-state logic: sft_rst beats en, and dropping en abandons the frame.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        snap_d  = snap_q;
        if (sft_rst) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            timer_d = '0;
            snap_d  = '0;
        end else if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    snap_d  = digits_i;
                    idx_d   = '0;
                    timer_d = BLANK_LD;
                    state_d = ST_BLANK;
                end
                ST_BLANK: begin
                    if (timer_q == '0) begin
                        timer_d = SHOW_LD;
                        state_d = ST_SHOW;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (timer_q == '0) begin
                        timer_d = BLANK_LD;
                        state_d = ST_BLANK;
                        if (idx_q == LAST_IDX) begin
                            idx_d  = '0;
                            snap_d = digits_i;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Decode from the next-cycle digit so anode and segments switch on the same edge.
    assign nib_s = snap_d[idx_d][3:0];

    seg7_dec u_dec (
        .nib_i (nib_s),
        .seg_o (dec_s)
    );

`ifdef SEG_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] lz_blank_s;

    // A digit is a leading zero if it and every digit above it are zero; digit 0 never is.
    always_comb begin
        logic nz_seen;
        nz_seen    = 1'b0;
        lz_blank_s = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            if (snap_d[k][3:0] != 4'h0) begin
                nz_seen = 1'b1;
            end else begin
                nz_seen = nz_seen;
            end
            lz_blank_s[k] = (k != 0) && !nz_seen;
        end
    end

    assign blank_digit_s = lz_blank_s[idx_d];
`else
    assign blank_digit_s = 1'b0;
`endif

    // Output decode from the next state, registered below.
    always_comb begin
        an_d    = '1;
        seg_d   = SEG_OFF;
        frame_d = 1'b0;
        if (state_d == ST_SHOW) begin
            an_d    = ~(NUM_DIGITS'(1) << idx_d);
            seg_d   = blank_digit_s ? SEG_OFF : dec_s;
            frame_d = (idx_d == LAST_IDX) && (timer_d == '0);
        end else begin
            an_d    = '1;
            seg_d   = SEG_OFF;
            frame_d = 1'b0;
        end
    end

    // State, snapshot and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= SEG_OFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            frame_q <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign frame_o = frame_q;

endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed 7-segment display scanner that reads the cascaded decimal counter digits and drives a common-anode, time-multiplexed LED display. It sits downstream of the counter chain. It snapshots all digit values once per frame, so a display frame never shows a half-updated count. It then cycles one digit at a time through a blank/show sequence with a programmable refresh rate.

## Interface
- NUM_DIGITS, 4, number of digits scanned (≥2)
- DATA_WIDTH, 4, width of one digit value
- REFRESH_DIV, 1000, clk cycles each digit is shown (≥1)
- BLANK_CYC, 2, clk cycles all anodes are off before each digit (≥1, anti-ghosting)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- sft_rst  in  1  synchronous reset, same effect as rst_n
- en  in  1  scan enable, level
- digits_i  in  NUM_DIGITS*DATA_WIDTH  digit k = digits_i[k*DATA_WIDTH +: DATA_WIDTH]; digit 0 is least significant
- an_o  out  NUM_DIGITS  anode selects, active-low, one-hot-low or all-ones
- seg_o  out  7  {g,f,e,d,c,b,a}, active-low
- frame_o  out  1  one-cycle pulse on the last show cycle of the final digit

## Operation
- All outputs are registered. Reset and sft_rst set: an_o = all ones, seg_o = 7'h7F, frame_o = 0, state IDLE, index 0, snapshot 0.
- FSM states:
  - IDLE: outputs off. When en=1, load the snapshot from digits_i, set index 0, go to BLANK.
  - BLANK: an_o all ones, seg_o 7'h7F for BLANK_CYC cycles, then go to SHOW.
  - SHOW: an_o[index]=0 and seg_o = decode(snapshot[index]) for REFRESH_DIV cycles.
    - If index < NUM_DIGITS-1: index+1, go to BLANK.
    - Otherwise: assert frame_o, reload the snapshot from digits_i, index wraps to 0, go to BLANK.
- en=0 in any state: the next state is IDLE and outputs turn off the next cycle. The partial frame is abandoned with no frame_o.
- Decode is hex 0–F. Examples: 0→7'h40, 1→7'h79, 5→7'h12, 8→7'h00, 9→7'h10, A→7'h08, F→7'h0E.
- Digit values wider than 4 bits use the low 4 bits only.
- Changes on digits_i between snapshots have no effect on the current frame.
- A single timer counts down from BLANK_CYC-1 or REFRESH_DIV-1 and reloads on each state change. Timer width is $clog2(max(REFRESH_DIV,BLANK_CYC)+1).

## Timing
- en rises and is sampled at edge t. At t+1 the FSM is in BLANK. At t+1+BLANK_CYC, an_o[0]=0 with valid seg_o.
- Digit period: BLANK_CYC+REFRESH_DIV cycles. Frame period: NUM_DIGITS*(BLANK_CYC+REFRESH_DIV) cycles.
- frame_o is high for exactly one cycle, coincident with the last SHOW cycle of digit NUM_DIGITS-1. The snapshot is taken at the edge ending that cycle.
- Segment and anode change on the same edge. There is never a cycle with an anode low and stale seg_o.
- sft_rst has priority over en. rst_n mid-frame forces the reset values asynchronously.

## Configuration
- SEG_SCAN_LZB_EN defined: leading-zero blanking is compiled in.
  - Zero digits above the most significant nonzero digit display seg_o=7'h7F.
  - Their anode still sequences, so frame timing is unchanged.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the snapshot.
- Undefined: all digits are always decoded, including leading zeros.

## Structure
- Package seg_scan_pkg holds:
  - the state enum (IDLE, BLANK, SHOW)
  - the active-low segment constants SEG_OFF=7'h7F and the 16 hex patterns
- Sub-module seg7_dec: combinational 4-bit → 7-bit active-low decoder, instantiated once on the muxed snapshot digit.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1.
- Reset: hold rst_n=0 → an_o=4'hF, seg_o=7'h7F, frame_o=0; release with en=0 → outputs stay off.
- Basic scan: digits_i=16'h1985, en=1 → an_o sequence E,D,B,7 with seg_o 12,00,10,79; each shown 4 cycles with 1 blank cycle between; frame_o every 20 cycles.
- Snapshot: change digits_i from 16'h0009 to 16'h0010 mid-frame → current frame still shows 9 on digit 0; the next frame shows 0 on digit 0 and 1 on digit 1.
- Leading-zero blanking: digits_i=16'h0007 with SEG_SCAN_LZB_EN → digits 3..1 show 7'h7F, digit 0 shows 7'h78. Without the macro → digits 3..1 show 7'h40.
- Disable mid-frame: drop en during digit 2 SHOW → outputs off the next cycle, no frame_o. Re-enable → the scan restarts at digit 0 after 1 blank cycle.
- sft_rst during SHOW with en=1 → next cycle reset values. With en still high → IDLE→BLANK restart as in the enable latency rule.
